// File: rtl/hex2ascii_conv_if.sv
// Handshake bundle for the hex-digit to ASCII stage: digit in, character out.
// The master drives a digit; the slave (the converter) returns the code and status.
interface hex2ascii_conv_if;
  logic       in_valid;
  logic [3:0] H;
  logic [6:0] A;
  logic       out_valid;
  logic       mismatch;

  modport master (
    output in_valid,
    output H,
    input  A,
    input  out_valid,
    input  mismatch
  );

  modport slave (
    input  in_valid,
    input  H,
    output A,
    output out_valid,
    output mismatch
  );
endinterface

// File: rtl/hex2ascii_conv.sv
// Registered hex digit to uppercase ASCII converter. Three independent encoders
// are compared every cycle, and any disagreement latches a sticky mismatch flag.
module hex2ascii_conv #(
  parameter logic [6:0] RESET_CHAR = 7'h30
) (
  input  logic             clk,
  input  logic             rst,
  hex2ascii_conv_if.slave  bus
);

  logic [3:0] h;
  assign h = bus.H;

  // Gate-level encoder: letters set bit 6, and their low bits are (H-9)[2:0].
  wire h0_n, h1_n, h2_n;
  wire h21_or, s6, s6_n, s3;
  wire h10_n, dec0, dec1, dec2;
  wire hi0, hi1, hi2, lo0, lo1, lo2;
  wire s0, s1, s2;

  not u_n0 (h0_n, h[0]);
  not u_n1 (h1_n, h[1]);
  not u_n2 (h2_n, h[2]);

  or  u_or21 (h21_or, h[2], h[1]);
  and u_a6   (s6, h[3], h21_or);
  not u_n6   (s6_n, s6);
  and u_a3   (s3, h[3], h2_n, h1_n);

  // (H-9) mod 8 equals H[2:0]-1 mod 8, so a 3-bit decrement is enough.
  buf  u_d0  (dec0, h0_n);
  xnor u_d1  (dec1, h[1], h[0]);
  and  u_b10 (h10_n, h1_n, h0_n);
  xor  u_d2  (dec2, h[2], h10_n);

  and u_hi0 (hi0, s6, dec0);
  and u_hi1 (hi1, s6, dec1);
  and u_hi2 (hi2, s6, dec2);
  and u_lo0 (lo0, s6_n, h[0]);
  and u_lo1 (lo1, s6_n, h[1]);
  and u_lo2 (lo2, s6_n, h[2]);
  or  u_m0  (s0, hi0, lo0);
  or  u_m1  (s1, hi1, lo1);
  or  u_m2  (s2, hi2, lo2);

  logic [6:0] s_code;
  assign s_code = {s6, s6_n, s6_n, s3, s2, s1, s0};

  logic [6:0] d_code;
  assign d_code = (h > 4'd9) ? ({3'b000, h} + 7'h37) : ({3'b000, h} + 7'h30);

  logic [6:0] b_code;
  always_comb begin
    b_code = RESET_CHAR;
    case (h)
      4'h0: b_code = 7'h30;
      4'h1: b_code = 7'h31;
      4'h2: b_code = 7'h32;
      4'h3: b_code = 7'h33;
      4'h4: b_code = 7'h34;
      4'h5: b_code = 7'h35;
      4'h6: b_code = 7'h36;
      4'h7: b_code = 7'h37;
      4'h8: b_code = 7'h38;
      4'h9: b_code = 7'h39;
      4'hA: b_code = 7'h41;
      4'hB: b_code = 7'h42;
      4'hC: b_code = 7'h43;
      4'hD: b_code = 7'h44;
      4'hE: b_code = 7'h45;
      4'hF: b_code = 7'h46;
      default: b_code = RESET_CHAR;
    endcase
  end

  logic cycle_mismatch;
  assign cycle_mismatch = (s_code != b_code) | (d_code != b_code);

  logic [6:0] a_q, a_d;
  logic       out_valid_q, out_valid_d;
  logic       mismatch_q, mismatch_d;

  always_comb begin
    a_d         = a_q;
    out_valid_d = 1'b0;
    mismatch_d  = mismatch_q;
    if (bus.in_valid) begin
      a_d         = b_code;
      out_valid_d = 1'b1;
      mismatch_d  = mismatch_q | cycle_mismatch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= RESET_CHAR;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.A         = a_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_hex2ascii_conv.sv
// Scoreboard bench for hex2ascii_conv: expected characters are queued on drive
// and popped when the converter reports a result.
module tb_hex2ascii_conv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex2ascii_conv_if bus ();

  hex2ascii_conv #(.RESET_CHAR(7'h30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [6:0] sb_q[$];
  logic [6:0] exp_a;

  function automatic logic [6:0] ref_ascii(input logic [3:0] hv);
    int c;
    if (hv < 4'd10) c = int'("0") + int'(hv);
    else            c = int'("A") + int'(hv) - 10;
    return c[6:0];
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] hv);
    bus.in_valid = v;
    bus.H        = hv;
    if (v) sb_q.push_back(ref_ascii(hv));
    @(posedge clk);
    #1;
    chk("out_valid", int'(bus.out_valid), int'(v));
    if (bus.out_valid) begin
      if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
      else exp_a = sb_q.pop_front();
    end
    chk("A", int'(bus.A), int'(exp_a));
    chk("mismatch", int'(bus.mismatch), 0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.H        = 4'hF;
    exp_a        = 7'h30;
    #1 rst = 1'b1;
    #1;
    chk("rst_A", int'(bus.A), 'h30);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mismatch", int'(bus.mismatch), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_A", int'(bus.A), 'h30);
      chk("rst_hold_out_valid", int'(bus.out_valid), 0);
      chk("rst_hold_mismatch", int'(bus.mismatch), 0);
    end
    #2 rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i));
    for (int i = 10; i < 16; i++) cycle(1'b1, 4'(i));

    cycle(1'b1, 4'hA);
    chk("A_lit_hA", int'(bus.A), 'b1000001);
    cycle(1'b1, 4'hF);
    chk("A_lit_hF", int'(bus.A), 'b1000110);

    cycle(1'b1, 4'h9);
    cycle(1'b1, 4'hA);
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'h0);

    cycle(1'b1, 4'h7);
    cycle(1'b0, 4'hC);
    cycle(1'b0, 4'hC);
    chk("hold_A", int'(bus.A), 'h37);

    cycle(1'b1, 4'h3);
    cycle(1'b1, 4'h4);
    bus.in_valid = 1'b1;
    bus.H        = 4'h5;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_A", int'(bus.A), 'h30);
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_mismatch", int'(bus.mismatch), 0);
    sb_q.delete();
    exp_a = 7'h30;
    #1 rst = 1'b0;

    cycle(1'b1, 4'h5);
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i));
    cycle(1'b0, 4'h2);
    chk("sb_drained", sb_q.size(), 0);
    chk("final_mismatch", int'(bus.mismatch), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex2ascii_conv.md
Name: hex2ascii_conv

Overview:
- Registered converter from one 4-bit hexadecimal digit to its 7-bit ASCII character code.
- Digits 0-9 map to '0'-'9'; digits A-F map to uppercase 'A'-'F'.
- Three internal encoder implementations run in parallel: gate-level, continuous-assign equations, and a case/if procedural block.
- Their results are cross-checked every cycle. The block sits in front of character-output and display logic as the hex-digit-to-text stage.

Parameters:
- RESET_CHAR, 7'h30, value driven on A while in reset (ASCII '0').

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  H is sampled on this cycle's rising edge
- H  input  4  hex digit to convert
- A  output  7  registered ASCII code of the last sampled H
- out_valid  output  1  A holds a fresh result this cycle
- mismatch  output  1  sticky flag: the three internal encoders disagreed

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst).
  - While rst=1, regardless of clk: A=RESET_CHAR, out_valid=0, mismatch=0.
  - Deassertion takes effect at the next rising edge.
- Mapping, 7-bit zero-extended arithmetic:
  - H in 0..9 -> A = H + 7'h30 (0x30..0x39).
  - H in 10..15 -> A = H + 7'h37 (0x41..0x46).
  - Every 4-bit code is defined; there are no don't-cares. Lowercase is never produced.
- Internal encoders, all purely combinational from H:
  - (S) Gate-level primitives only, using these per-bit equations:
    - A6 = H3&(H2|H1)
    - A5 = A4 = ~A6
    - A3 = H3&~H2&~H1
    - A2..A0 = low three bits of (H-9) when A6=1, else H2..H0
  - (D) Continuous-assign equations.
  - (B) Procedural block with a full case or if/else on H that covers all 16 codes.
- Output selection and checking:
  - A is registered from encoder (B).
  - Cycle mismatch = (S != B) | (D != B).
- Timing, latency 1 cycle:
  - On a rising edge with in_valid=1: A <= converted H; out_valid <= 1; mismatch <= mismatch | cycle mismatch.
  - On a rising edge with in_valid=0: A holds its value; out_valid <= 0; mismatch holds.
- Back-to-back in_valid: one result per cycle, no stalls, no backpressure.
- mismatch stays at 1 until rst. In correct hardware it is always 0.
- Reset mid-stream: the in-flight result is discarded and out_valid drops immediately (asynchronously).
- A wraps nowhere: the maximum output is 0x46.

Test Plan:
- Reset: assert rst with in_valid=1, H=4'hF -> A=7'h30, out_valid=0, mismatch=0 immediately and for every clock while held.
- Digit sweep: H=0..9 with in_valid=1 each cycle -> one cycle later A=0x30..0x39 ('0'..'9') in order, out_valid=1 each cycle, mismatch=0.
- Letter sweep: H=A..F -> A=0x41..0x46 ('A'..'F'). Specifically H=4'hA -> 7'b1000001 and H=4'hF -> 7'b1000110.
- Boundaries: H=9 then H=A on consecutive cycles -> A=0x39 then 0x41; H=F then H=0 -> A=0x46 then 0x30.
- Hold: present H=7, then in_valid=0 with H changed to C -> A stays 0x37, out_valid=0 for the idle cycles.
- Async reset mid-stream: rst pulsed between clock edges during a sweep -> A=0x30 and out_valid=0 at once, before the next edge. The first valid H after release converts correctly, and mismatch stays 0 over all 16 codes.
